// File: rtl/switch_ctrl_pkg.sv
// Shared types and constants for the counter-path switch conditioning logic.
package switch_ctrl_pkg;

   typedef enum logic {STABLE = 1'b0, CHECK = 1'b1} db_state_t;
   typedef enum logic {RUN = 1'b0, HOLD = 1'b1}     rst_state_t;

   localparam int DB_CYCLES_DEF   = 1000000;
   localparam int RST_HOLD_DEF    = 16;
   localparam int SYNC_STAGES_DEF = 2;

   // VIO bus layout: upper pair is the virtual reset, lower pair the virtual direction
   localparam int VRST_HI = 3;
   localparam int VRST_LO = 2;
   localparam int VDIR_HI = 1;
   localparam int VDIR_LO = 0;

endpackage

// File: rtl/switch_ctrl_cond_debounce_cell.sv
// Synchroniser plus two-state debouncer for one bouncy slide switch.
module debounce_cell
   import switch_ctrl_pkg::*;
#(
   parameter int   DB_CYCLES   = DB_CYCLES_DEF,
   parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clock,
   input  logic rst_n,
   input  logic din_async,
   output logic db_out,
   output logic busy
);

   localparam int            CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   din_sync;
   db_state_t              state, state_nx;
   logic [CW-1:0]          cnt, cnt_nx;
   logic                   db_nx;

   // Synchroniser resets to the debounced reset value so release is quiet
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) sync_q <= {SYNC_STAGES{RST_VAL}};
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], din_async};
   end

   assign din_sync = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state  <= STABLE;
         cnt    <= '0;
         db_out <= RST_VAL;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         db_out <= db_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      db_nx    = db_out;
      case (state)
         STABLE: begin
            if (din_sync != db_out) begin
               state_nx = CHECK;
               cnt_nx   = '0;
            end
         end
         CHECK: begin
            // Any return to the accepted level abandons the candidate edge
            if (din_sync == db_out) begin
               state_nx = STABLE;
            end else if (cnt == CNT_LAST) begin
               db_nx    = din_sync;
               state_nx = STABLE;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: state_nx = STABLE;
      endcase
   end

   always_comb begin
      busy = (state == CHECK);
   end

endmodule

// File: rtl/switch_ctrl_cond.sv
// Conditions SW0/SW1 and the VIO control bus into a held counter reset,
// a clean direction level and single-cycle ILA event strobes.
module switch_ctrl_cond
   import switch_ctrl_pkg::*;
#(
   parameter int DB_CYCLES   = DB_CYCLES_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int RST_HOLD    = RST_HOLD_DEF
) (
   input  logic       clock,
   input  logic       rst_n,
   input  logic       sw_rst_n,
   input  logic       sw_dir,
   input  logic [3:0] vio_din,
   output logic       cnt_rst_n,
   output logic       cnt_dir,
   output logic       dir_chg,
   output logic       rst_evt,
   output logic       db_busy
);

   localparam int            HW        = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

   logic                        sw_rst_n_db, sw_dir_db, rst_busy, dir_busy;
   logic [SYNC_STAGES-1:0][3:0] vio_q;
   logic [3:0]                  vio_sync;
   logic                        vrst, vdir, rst_req, dir_next;
   rst_state_t                  state, state_nx;
   logic [HW-1:0]               hold_cnt, hold_nx;
   logic                        run_nx, evt_nx;

   debounce_cell #(
      .DB_CYCLES(DB_CYCLES), .SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)
   ) u_db_rst (
      .clock(clock), .rst_n(rst_n), .din_async(sw_rst_n),
      .db_out(sw_rst_n_db), .busy(rst_busy)
   );

   debounce_cell #(
      .DB_CYCLES(DB_CYCLES), .SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)
   ) u_db_dir (
      .clock(clock), .rst_n(rst_n), .din_async(sw_dir),
      .db_out(sw_dir_db), .busy(dir_busy)
   );

   assign db_busy = rst_busy | dir_busy;

   // VIO is already clean, only synchronised
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) vio_q <= '0;
      else        vio_q <= {vio_q[SYNC_STAGES-2:0], vio_din};
   end

   assign vio_sync = vio_q[SYNC_STAGES-1];
   assign vrst     = vio_sync[VRST_HI] & vio_sync[VRST_LO];
   assign vdir     = vio_sync[VDIR_HI] & vio_sync[VDIR_LO];
   assign rst_req  = ~sw_rst_n_db | vrst;
   assign dir_next = sw_dir_db | vdir;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state    <= HOLD;
         hold_cnt <= '0;
      end else begin
         state    <= state_nx;
         hold_cnt <= hold_nx;
      end
   end

   always_comb begin
      state_nx = state;
      hold_nx  = hold_cnt;
      case (state)
         RUN: begin
            if (rst_req) begin
               state_nx = HOLD;
               hold_nx  = '0;
            end
         end
         HOLD: begin
            // Counter saturates; a lingering request just extends the hold
            if (hold_cnt == HOLD_LAST) begin
               if (!rst_req) state_nx = RUN;
            end else begin
               hold_nx = hold_cnt + 1'b1;
            end
         end
         default: state_nx = HOLD;
      endcase
   end

   always_comb begin
      run_nx = (state_nx == RUN);
      evt_nx = (state == RUN) && (state_nx == HOLD);
   end

   // Outputs come straight from flops so the counter sees no decode glitches
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         cnt_rst_n <= 1'b0;
         rst_evt   <= 1'b0;
         cnt_dir   <= 1'b0;
         dir_chg   <= 1'b0;
      end else begin
         cnt_rst_n <= run_nx;
         rst_evt   <= evt_nx;
         cnt_dir   <= dir_next;
         dir_chg   <= dir_next ^ cnt_dir;
      end
   end

endmodule

// File: tb/tb_switch_ctrl_cond.sv
// Self-checking bench: directed scenarios plus random switch/VIO activity
// compared every cycle against a behavioural model.
module tb_switch_ctrl_cond;

   localparam int DBC  = 4;
   localparam int SYNC = 2;
   localparam int RH   = 3;

   logic       clock = 1'b0;
   logic       rst_n;
   logic       sw_rst_n, sw_dir;
   logic [3:0] vio_din;
   logic       cnt_rst_n, cnt_dir, dir_chg, rst_evt, db_busy;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 0;

   switch_ctrl_cond #(.DB_CYCLES(DBC), .SYNC_STAGES(SYNC), .RST_HOLD(RH)) dut (
      .clock(clock), .rst_n(rst_n), .sw_rst_n(sw_rst_n), .sw_dir(sw_dir),
      .vio_din(vio_din), .cnt_rst_n(cnt_rst_n), .cnt_dir(cnt_dir),
      .dir_chg(dir_chg), .rst_evt(rst_evt), .db_busy(db_busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: raw inputs delayed SYNC edges, a switch is accepted once it
   // has disagreed with the accepted level for DBC+1 consecutive edges, and the
   // counter reset is released once it has been low RH cycles with no request.
   logic       ds_r [SYNC];
   logic       ds_d [SYNC];
   logic [3:0] ds_v [SYNC];
   logic       db_r, db_d;
   int         run_r, run_d, low_len;
   logic       m_rst_n, m_dir, m_chg, m_evt;

   task automatic deb(input logic s, inout logic db, inout int run);
      if (s != db) begin
         run++;
         if (run == DBC + 1) begin
            db  = s;
            run = 0;
         end
      end else begin
         run = 0;
      end
   endtask

   always @(posedge clock or negedge rst_n) begin
      logic req, dnx;
      if (!rst_n) begin
         for (int i = 0; i < SYNC; i++) begin
            ds_r[i] = 1'b1; ds_d[i] = 1'b0; ds_v[i] = 4'h0;
         end
         db_r = 1'b1; db_d = 1'b0; run_r = 0; run_d = 0;
         m_rst_n = 1'b0; m_dir = 1'b0; m_chg = 1'b0; m_evt = 1'b0;
         low_len = 1;
      end else begin
         req = !db_r || (ds_v[SYNC-1][3] && ds_v[SYNC-1][2]);
         dnx = db_d || (ds_v[SYNC-1][1] && ds_v[SYNC-1][0]);
         m_evt = 1'b0;
         if (m_rst_n) begin
            if (req) begin
               m_rst_n = 1'b0; m_evt = 1'b1; low_len = 1;
            end
         end else if (low_len >= RH && !req) begin
            m_rst_n = 1'b1;
         end else begin
            low_len++;
         end
         m_chg = (dnx != m_dir);
         m_dir = dnx;
         deb(ds_r[SYNC-1], db_r, run_r);
         deb(ds_d[SYNC-1], db_d, run_d);
         for (int i = SYNC - 1; i > 0; i--) begin
            ds_r[i] = ds_r[i-1]; ds_d[i] = ds_d[i-1]; ds_v[i] = ds_v[i-1];
         end
         ds_r[0] = sw_rst_n; ds_d[0] = sw_dir; ds_v[0] = vio_din;
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         chk("cnt_rst_n", cnt_rst_n, m_rst_n);
         chk("cnt_dir", cnt_dir, m_dir);
         chk("dir_chg", dir_chg, m_chg);
         chk("rst_evt", rst_evt, m_evt);
         chk("db_busy", db_busy, (run_r > 0) || (run_d > 0));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Edges from the stimulus change until the selected condition is seen
   task automatic wait_lat(input string tag, input int sel, input int exp);
      int n;
      bit hit;
      n = -1;
      hit = 0;
      for (int k = 1; k <= 30 && !hit; k++) begin
         @(negedge clock);
         case (sel)
            0:       hit = cnt_dir;
            1:       hit = cnt_rst_n;
            default: hit = !cnt_rst_n;
         endcase
         if (hit) n = k;
      end
      chk(tag, n, exp);
   endtask

   task automatic chk_rst_vals(input string tag);
      chk({tag, "_rst_n"}, cnt_rst_n, 1'b0);
      chk({tag, "_dir"},   cnt_dir,   1'b0);
      chk({tag, "_chg"},   dir_chg,   1'b0);
      chk({tag, "_evt"},   rst_evt,   1'b0);
      chk({tag, "_busy"},  db_busy,   1'b0);
   endtask

   initial begin
      int evts;
      rst_n = 1'b0; sw_rst_n = 1'b1; sw_dir = 1'b0; vio_din = 4'h0;
      tick(3);
      chk_rst_vals("reset");
      chk_en = 1;
      #2 rst_n = 1'b1;
      wait_lat("rel_lat", 1, RH);
      tick(4);

      sw_dir = 1'b1;
      wait_lat("dir_lat", 0, SYNC + DBC + 2);
      chk("dir_chg_pulse", dir_chg, 1'b1);
      tick(6);
      sw_dir = 1'b0;
      tick(12);

      // Bounce train shorter than the debounce window
      for (int i = 0; i < 4; i++) begin
         sw_dir = ~i[0];
         tick(1);
      end
      sw_dir = 1'b0;
      tick(12);
      chk("bounce_dir", cnt_dir, 1'b0);
      chk("bounce_busy", db_busy, 1'b0);

      evts = 0;
      for (int i = 0; i < 35; i++) begin
         sw_rst_n = (i >= 10);
         tick(1);
         evts += int'(rst_evt);
      end
      chk("sw_rst_evts", evts, 1);
      chk("sw_rst_done", cnt_rst_n, 1'b1);

      vio_din = 4'b0100;
      tick(8);
      chk("vio_single", cnt_rst_n, 1'b1);
      vio_din = 4'b1100;
      wait_lat("vrst_lat", 2, SYNC + 1);
      chk("vrst_evt", rst_evt, 1'b1);
      vio_din = 4'b0000;
      tick(8);
      vio_din = 4'b0011;
      tick(6);
      chk("vdir", cnt_dir, 1'b1);
      vio_din = 4'b0000;
      tick(6);

      // Global reset while the direction cell is mid-check
      sw_dir = 1'b1;
      tick(4);
      chk("mid_busy", db_busy, 1'b1);
      #2 rst_n = 1'b0;
      #1 chk_rst_vals("mid");
      tick(2);
      #2 rst_n = 1'b1;
      wait_lat("dir_relat", 0, SYNC + DBC + 2);
      tick(8);

      for (int i = 0; i < 60; i++) begin
         sw_dir   = 1'($urandom_range(0, 1));
         sw_rst_n = ($urandom_range(0, 5) != 0);
         case ($urandom_range(0, 4))
            0:       vio_din = 4'b0000;
            1:       vio_din = 4'b0100;
            2:       vio_din = 4'b1100;
            3:       vio_din = 4'b0011;
            default: vio_din = 4'($urandom);
         endcase
         tick($urandom_range(1, 12));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
